// File: rtl/muldiv_iterative_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iterative_unit
// Brief    : Iterative RV32M multiply/divide unit with fixed WIDTH+1 latency.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_iterative_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             flush,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int            c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [2:0]             r_f3;
   logic                   r_neg;
   logic                   r_neg_rem;
   logic [c_cnt_w-1:0]     r_cnt;
   logic [WIDTH-1:0]       r_opd;
   logic [2*WIDTH-1:0]     r_prod;
   logic                   r_busy;
   logic                   r_done;
   logic [WIDTH-1:0]       r_result;

   logic                   w_a_signed;
   logic                   w_b_signed;
   logic                   w_sa;
   logic                   w_sb;
   logic [WIDTH-1:0]       w_abs_a;
   logic [WIDTH-1:0]       w_abs_b;
   logic [WIDTH:0]         w_mul_sum;
   logic [2*WIDTH-1:0]     w_mul_nxt;
   logic [WIDTH:0]         w_div_sh;
   logic [WIDTH:0]         w_div_diff;
   logic [2*WIDTH-1:0]     w_div_nxt;
   logic [2*WIDTH-1:0]     w_prod_nxt;
   logic [2*WIDTH-1:0]     w_prod_neg;
   logic [WIDTH-1:0]       w_q_neg;
   logic [WIDTH-1:0]       w_r_neg;
   logic [WIDTH-1:0]       w_result;

   assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b110);
   assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
   assign w_sa       = w_a_signed & op_a[WIDTH-1];
   assign w_sb       = w_b_signed & op_b[WIDTH-1];
   assign w_abs_a    = w_sa ? -op_a : op_a;
   assign w_abs_b    = w_sb ? -op_b : op_b;

   // Product and division share r_prod: upper half is accumulator/remainder,
   // lower half is multiplier/quotient shifting through.
   always_comb begin
      w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opd} : '0);
      w_mul_nxt  = {w_mul_sum, r_prod[WIDTH-1:1]};
      w_div_sh   = r_prod[2*WIDTH-1:WIDTH-1];
      w_div_diff = w_div_sh - {1'b0, r_opd};
      w_div_nxt  = w_div_diff[WIDTH] ? {w_div_sh[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0}
                                     : {w_div_diff[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
      w_prod_nxt = r_f3[2] ? w_div_nxt : w_mul_nxt;
      w_prod_neg = -w_prod_nxt;
      w_q_neg    = -w_prod_nxt[WIDTH-1:0];
      w_r_neg    = -w_prod_nxt[2*WIDTH-1:WIDTH];
      case (r_f3)
         3'b000:                 w_result = r_neg ? w_prod_neg[WIDTH-1:0] : w_prod_nxt[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: w_result = r_neg ? w_prod_neg[2*WIDTH-1:WIDTH]
                                                  : w_prod_nxt[2*WIDTH-1:WIDTH];
         3'b100, 3'b101:         w_result = r_neg ? w_q_neg : w_prod_nxt[WIDTH-1:0];
         default:                w_result = r_neg_rem ? w_r_neg : w_prod_nxt[2*WIDTH-1:WIDTH];
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_CALC;
         S_CALC:  if (r_cnt == c_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (flush) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_f3      <= '0;
         r_neg     <= 1'b0;
         r_neg_rem <= 1'b0;
         r_cnt     <= '0;
         r_opd     <= '0;
         r_prod    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_result  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_done  <= (w_state_nxt == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (start && !flush) begin
                  r_f3      <= funct3;
                  // A zero divisor must not flip the all-ones quotient.
                  r_neg     <= (w_sa ^ w_sb) & (|op_b);
                  r_neg_rem <= w_sa;
                  r_cnt     <= '0;
                  r_opd     <= funct3[2] ? w_abs_b : w_abs_a;
                  r_prod    <= {{WIDTH{1'b0}}, (funct3[2] ? w_abs_a : w_abs_b)};
               end
            end
            S_CALC: begin
               r_prod <= w_prod_nxt;
               r_cnt  <= r_cnt + 1'b1;
               if (!flush && (r_cnt == c_last)) r_result <= w_result;
            end
            default: ;
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iterative_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_iterative_unit
// Brief    : Directed scoreboard bench for the iterative RV32M mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_iterative_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        flush;
   logic [2:0]  funct3;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int          n_cmp;
   int          n_err;
   logic [31:0] sb[$];

   muldiv_iterative_unit #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .flush  (flush),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion expected $finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] sa, sbv, ua, ub, p;
      logic        ovf;
      sa  = {{32{a[31]}}, a};
      sbv = {{32{b[31]}}, b};
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      case (f)
         3'd0: begin p = ua * ub;  return p[31:0];  end
         3'd1: begin p = sa * sbv; return p[63:32]; end
         3'd2: begin p = sa * ub;  return p[63:32]; end
         3'd3: begin p = ua * ub;  return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Caller is at a negedge; start is sampled on the following posedge.
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit push);
      start  = 1'b1;
      funct3 = f;
      op_a   = a;
      op_b   = b;
      if (push) sb.push_back(exp);
      @(posedge clk);
      #1;
      start  = 1'b0;
      funct3 = 3'($urandom_range(0, 7));
      op_a   = $urandom;
      op_b   = $urandom;
   endtask

   task automatic finish_op(input string tag, input int c0);
      int          lat;
      logic [31:0] exp;
      lat = 0;
      exp = '0;
      for (int c = c0; c <= 40; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = c;
            break;
         end
         check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      end
      check({tag, "_lat"}, lat, 32'd33);
      if (lat != 0) begin
         check({tag, "_busy_d"}, {31'b0, busy}, 32'd1);
         n_cmp++;
         assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL %s_sb: observed empty queue expected pending entry", tag);
         end
         if (sb.size() != 0) begin
            exp = sb.pop_front();
            check({tag, "_res"}, result, exp);
         end
         @(negedge clk);
         check({tag, "_idle"}, {30'b0, busy, done}, 32'd0);
         check({tag, "_hold"}, result, exp);
      end
   endtask

   initial begin
      int          n_done;
      logic [31:0] a;
      logic [31:0] b;
      n_cmp  = 0;
      n_err  = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      flush  = 1'b0;
      funct3 = 3'b000;
      op_a   = '0;
      op_b   = '0;
      repeat (3) @(negedge clk);
      check("rst_busy",   {31'b0, busy}, 32'd0);
      check("rst_done",   {31'b0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed ops, issued back-to-back in the first IDLE cycle.
      issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);         finish_op("mul", 1);
      issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1); finish_op("mulh", 1);
      issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1); finish_op("mulhu", 1);
      issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); finish_op("mulhsu", 1);
      issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);         finish_op("div", 1);
      issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);         finish_op("rem", 1);
      issue(3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b1);         finish_op("divu", 1);
      issue(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);                 finish_op("divu0", 1);
      issue(3'b111, 32'd5, 32'd0, 32'd5, 1'b1);                         finish_op("remu0", 1);
      issue(3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b1);         finish_op("div0neg", 1);
      issue(3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b1);         finish_op("rem0neg", 1);
      issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1); finish_op("div_ovf", 1);
      issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);         finish_op("rem_ovf", 1);

      for (int k = 0; k < 8; k++) begin
         a = $urandom;
         b = (k >= 4) ? ($urandom >> $urandom_range(0, 24)) : $urandom;
         issue(3'(k), a, b, model(3'(k), a, b), 1'b1);
         finish_op("rnd", 1);
      end

      // Second start during CALC must be ignored.
      issue(3'b101, 32'd100, 32'd7, 32'd14, 1'b1);
      repeat (10) @(negedge clk);
      start  = 1'b1;
      funct3 = 3'b000;
      op_a   = 32'd3;
      op_b   = 32'd3;
      @(posedge clk);
      #1;
      start  = 1'b0;
      finish_op("start_busy", 11);

      // Flush mid-CALC: back to IDLE, no DONE, result retained.
      @(negedge clk);
      issue(3'b100, 32'd1000, 32'd3, 32'd0, 1'b0);
      repeat (5) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush_busy",   {31'b0, busy}, 32'd0);
      check("flush_done",   {31'b0, done}, 32'd0);
      check("flush_result", result, 32'd14);
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      check("flush_nodone", n_done, 32'd0);
      check("flush_hold",   result, 32'd14);

      // Flush beats a simultaneous start in IDLE.
      start = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      check("flush_vs_start", {31'b0, busy}, 32'd0);

      // Asynchronous reset mid-CALC clears outputs immediately.
      issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_busy",   {31'b0, busy}, 32'd0);
      check("arst_done",   {31'b0, done}, 32'd0);
      check("arst_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
      finish_op("post_rst", 1);

      check("sb_empty", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
